lsu_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the RISC-V core's memory stage and a single data-memory port with variable wait states. It takes the decoded `rd`/`wr`/`lsbwh` controls plus the ALU-computed address. It drives byte enables, shifts and aligns store data, and waits for the memory acknowledge. It returns sign- or zero-extended load data and stalls the pipeline while the access is outstanding.

---
 rtl/lsu_sequencer_if.sv | 44 ++++
 rtl/lsu_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_sequencer_if.sv
// lsu_sequencer_if
//   Bundles the signals between the memory-stage request side, the load/store
//   sequencer and the single data-memory port.
//   Request side : req_valid, req_rd, req_wr, req_lsbwh[2:0], req_addr[31:0],
//                  req_wdata[31:0]  -> sequencer
//                  stall, resp_valid, resp_rdata[31:0], resp_err <- sequencer
//   Memory side  : mem_req, mem_we, mem_be[3:0], mem_addr[31:0],
//                  mem_wdata[31:0]  <- sequencer
//                  mem_ack, mem_rdata[31:0] -> sequencer
//   modport slave  : the sequencer's view.
//   modport master : the environment (core pipeline plus memory) view.
interface lsu_sequencer_if;
   logic        req_valid;
   logic        req_rd;
   logic        req_wr;
   logic [2:0]  req_lsbwh;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_rd, req_wr, req_lsbwh, req_addr, req_wdata,
      input  mem_ack, mem_rdata,
      output stall, resp_valid, resp_rdata, resp_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_rd, req_wr, req_lsbwh, req_addr, req_wdata,
      output mem_ack, mem_rdata,
      input  stall, resp_valid, resp_rdata, resp_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_sequencer.sv
// lsu_sequencer
//   Multi-cycle load/store sequencer between the core memory stage and a
//   single wait-stated data-memory port. Accepts one access, drives byte
//   enables and lane-shifted store data, waits for mem_ack (bounded by
//   TIMEOUT cycles) and returns sign/zero-extended load data.
//   Parameters : TIMEOUT (1..255) bus-wait cycles before an abort.
//   Ports      : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - lsu_sequencer_if.slave (request, response, memory)
//   Macro      : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses are rejected with resp_err; otherwise the low
//                address bits are forced to natural alignment.
module lsu_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_sequencer_if.slave    bus
);
   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
   typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B}      size_t;

   localparam logic [7:0] TO8 = 8'(TIMEOUT);

   state_t      r_state;
   size_t       r_size;
   logic        r_sext;
   logic [1:0]  r_a;
   logic [7:0]  r_cnt;
   logic        r_mem_req, r_mem_we;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_addr, r_mem_wdata;
   logic        r_resp_valid, r_resp_err;
   logic [31:0] r_resp_rdata;

   size_t       w_size;
   logic        w_sext, w_code_ok, w_ok;
   logic [1:0]  w_a;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_shifted, w_ldata;

   // Request decode: size, sign, effective lane offset, enables and store data.
   always_comb begin
      w_size    = SZ_W;
      w_sext    = 1'b0;
      w_code_ok = 1'b0;
      if (bus.req_rd) begin
         case (bus.req_lsbwh)
            3'd0:    begin w_size = SZ_W; w_code_ok = 1'b1; end
            3'd1:    begin w_size = SZ_H; w_sext = 1'b1; w_code_ok = 1'b1; end
            3'd2:    begin w_size = SZ_H; w_code_ok = 1'b1; end
            3'd3:    begin w_size = SZ_B; w_code_ok = 1'b1; end
            3'd4:    begin w_size = SZ_B; w_sext = 1'b1; w_code_ok = 1'b1; end
            default: w_code_ok = 1'b0;
         endcase
      end else begin
         case (bus.req_lsbwh)
            3'd0:    begin w_size = SZ_W; w_code_ok = 1'b1; end
            3'd1:    begin w_size = SZ_H; w_code_ok = 1'b1; end
            3'd2:    begin w_size = SZ_B; w_code_ok = 1'b1; end
            default: w_code_ok = 1'b0;
         endcase
      end

      case (w_size)
         SZ_H:    w_a = {bus.req_addr[1], 1'b0};
         SZ_B:    w_a = bus.req_addr[1:0];
         default: w_a = 2'b00;
      endcase

      w_ok = (bus.req_rd ^ bus.req_wr) & w_code_ok;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((w_size == SZ_H && bus.req_addr[0]) ||
          (w_size == SZ_W && bus.req_addr[1:0] != 2'b00))
         w_ok = 1'b0;
`endif

      case (w_size)
         SZ_H:    w_be = 4'b0011 << w_a;
         SZ_B:    w_be = 4'b0001 << w_a;
         default: w_be = 4'b1111;
      endcase

      w_wdata = '0;
      if (bus.req_wr) begin
         case (w_size)
            SZ_H:    w_wdata = {16'h0, bus.req_wdata[15:0]} << {w_a, 3'b000};
            SZ_B:    w_wdata = {24'h0, bus.req_wdata[7:0]}  << {w_a, 3'b000};
            default: w_wdata = bus.req_wdata;
         endcase
      end
   end

   // Load extraction from the word returned with mem_ack.
   always_comb begin
      w_shifted = bus.mem_rdata >> {r_a, 3'b000};
      case (r_size)
         SZ_H:    w_ldata = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
         SZ_B:    w_ldata = {{24{r_sext & w_shifted[7]}},  w_shifted[7:0]};
         default: w_ldata = w_shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_size       <= SZ_W;
         r_sext       <= 1'b0;
         r_a          <= 2'b00;
         r_cnt        <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_be     <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
               if (bus.req_valid) begin
                  if (w_ok) begin
                     r_state     <= S_BUS;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= bus.req_wr;
                     r_mem_be    <= w_be;
                     r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                     r_mem_wdata <= w_wdata;
                     r_a         <= w_a;
                     r_size      <= w_size;
                     r_sext      <= w_sext;
                     r_cnt       <= '0;
                  end else begin
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end
               end
            end
            S_BUS: begin
               // Ack has priority, so an ack in the final wait cycle succeeds.
               if (bus.mem_ack || (r_cnt + 8'd1 == TO8)) begin
                  r_state      <= S_RESP;
                  r_mem_req    <= 1'b0;
                  r_mem_we     <= 1'b0;
                  r_mem_be     <= '0;
                  r_mem_addr   <= '0;
                  r_mem_wdata  <= '0;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= ~bus.mem_ack;
                  r_resp_rdata <= (bus.mem_ack && !r_mem_we) ? w_ldata : '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               r_state      <= S_IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Combinational so the front-end registers hold in the accept cycle;
   // gated by rst_n so it also drops at once when reset is asserted.
   assign bus.stall      = rst_n & (((r_state == S_IDLE) & bus.req_valid) |
                                    (r_state == S_BUS));
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_be     = r_mem_be;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer
//   Directed bench for lsu_sequencer (TIMEOUT=4). Expected responses are
//   queued when an access is driven and popped when resp_valid appears.
module tb_lsu_sequencer;
   localparam int TO = 4;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic clk;
   logic rst_n;
   lsu_sequencer_if bus ();

   lsu_sequencer #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_bad = 0;
   resp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // waits < 0 means memory never acknowledges.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] code, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input logic exp_bus,
                         input logic [3:0] ebe, input logic [31:0] eaddr,
                         input logic [31:0] ewdata, input logic eerr,
                         input logic [31:0] erdata, input bit late_ack);
      resp_t e;
      int    cyc, nbus, enbus;
      bit    done;
      e.err   = eerr;
      e.rdata = erdata;
      sb.push_back(e);
      enbus = !exp_bus ? 0 : (waits < 0 ? TO : waits + 1);

      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rd    = rd;
      bus.req_wr    = wr;
      bus.req_lsbwh = code;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      #1 chk({tag, " stall T0"}, 32'(bus.stall), 32'd1);

      cyc = 0; nbus = 0; done = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 32'hDEAD_BEEF;
         if (bus.mem_req) begin
            nbus++;
            if (nbus == 1) begin
               chk({tag, " mem_be"},   32'(bus.mem_be), 32'(ebe));
               chk({tag, " mem_addr"}, bus.mem_addr, eaddr);
               chk({tag, " mem_we"},   32'(bus.mem_we), 32'(wr));
               if (wr) chk({tag, " mem_wdata"}, bus.mem_wdata, ewdata);
            end
            chk({tag, " stall BUS"}, 32'(bus.stall), 32'd1);
            if (waits >= 0 && nbus == waits + 1) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = rdata;
            end
         end
         if (bus.resp_valid) begin
            done = 1;
            chk({tag, " stall RESP"}, 32'(bus.stall), 32'd0);
            if (sb.size() == 0) begin
               n_vec++; n_bad++;
               $error("FAIL %s: unexpected response, scoreboard empty", tag);
            end else begin
               e = sb.pop_front();
               chk({tag, " resp_err"},   32'(bus.resp_err), 32'(e.err));
               chk({tag, " resp_rdata"}, bus.resp_rdata, e.rdata);
            end
            chk({tag, " latency"},    32'(cyc),  32'(enbus + 1));
            chk({tag, " bus cycles"}, 32'(nbus), 32'(enbus));
            bus.req_valid = 1'b0;
            bus.req_rd    = 1'b0;
            bus.req_wr    = 1'b0;
         end
      end
      if (!done) begin
         n_vec++; n_bad++;
         $error("FAIL %s: no resp_valid within 40 cycles", tag);
         bus.req_valid = 1'b0;
      end else begin
         @(negedge clk);
         bus.mem_ack = late_ack;
         chk({tag, " idle resp_valid"}, 32'(bus.resp_valid), 32'd0);
         chk({tag, " idle resp_rdata"}, bus.resp_rdata, 32'd0);
         chk({tag, " idle resp_err"},   32'(bus.resp_err), 32'd0);
         if (late_ack) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk({tag, " late ack mem_req"},    32'(bus.mem_req), 32'd0);
            chk({tag, " late ack resp_valid"}, 32'(bus.resp_valid), 32'd0);
         end
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_rd    = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_lsbwh = 3'd0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset mem_req",    32'(bus.mem_req), 32'd0);
      chk("reset mem_be",     32'(bus.mem_be), 32'd0);
      chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("reset resp_rdata", bus.resp_rdata, 32'd0);
      chk("reset stall",      32'(bus.stall), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      //     tag        rd wr code addr           wdata          rdata          waits bus be       eaddr          ewdata         err  erdata         late
      access("LB",      1, 0, 3'd4, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0,    1, 4'b1000, 32'h0000_1000, 32'h0,         1'b0, 32'hFFFF_FF80, 0);
      access("SH",      0, 1, 3'd1, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0,         3,    1, 4'b1100, 32'h0000_2000, 32'hBEEF_0000, 1'b0, 32'h0,         0);
      access("LHU",     1, 0, 3'd2, 32'h0000_0000, 32'h0,         32'h1234_8001, 0,    1, 4'b0011, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_8001, 0);
      access("LH",      1, 0, 3'd1, 32'h0000_0000, 32'h0,         32'h1234_8001, 1,    1, 4'b0011, 32'h0000_0000, 32'h0,         1'b0, 32'hFFFF_8001, 0);
      access("SB",      0, 1, 3'd2, 32'h0000_3001, 32'h1234_5678, 32'h0,         0,    1, 4'b0010, 32'h0000_3000, 32'h0000_7800, 1'b0, 32'h0,         0);
      access("LBU",     1, 0, 3'd3, 32'h0000_3002, 32'h0,         32'hAABB_CCDD, 2,    1, 4'b0100, 32'h0000_3000, 32'h0,         1'b0, 32'h0000_00BB, 0);
      access("SW",      0, 1, 3'd0, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,         0,    1, 4'b1111, 32'h0000_4000, 32'hCAFE_F00D, 1'b0, 32'h0,         0);
      access("ACK@TO",  1, 0, 3'd0, 32'h0000_5000, 32'h0,         32'h1357_9BDF, TO-1, 1, 4'b1111, 32'h0000_5000, 32'h0,         1'b0, 32'h1357_9BDF, 0);
      access("TIMEOUT", 1, 0, 3'd0, 32'h0000_6000, 32'h0,         32'h0,         -1,   1, 4'b1111, 32'h0000_6000, 32'h0,         1'b1, 32'h0,         1);
      access("RD+WR",   1, 1, 3'd0, 32'h0000_7000, 32'h0,         32'h0,         0,    0, 4'b0000, 32'h0,         32'h0,         1'b1, 32'h0,         0);
      access("NONE",    0, 0, 3'd0, 32'h0000_7000, 32'h0,         32'h0,         0,    0, 4'b0000, 32'h0,         32'h0,         1'b1, 32'h0,         0);
      access("LD code5",1, 0, 3'd5, 32'h0000_7000, 32'h0,         32'h0,         0,    0, 4'b0000, 32'h0,         32'h0,         1'b1, 32'h0,         0);
      access("ST code3",0, 1, 3'd3, 32'h0000_7000, 32'h0,         32'h0,         0,    0, 4'b0000, 32'h0,         32'h0,         1'b1, 32'h0,         0);
`ifdef LSU_MISALIGN_TRAP_EN
      access("LW mis",  1, 0, 3'd0, 32'h0000_2002, 32'h0,         32'h0,         0,    0, 4'b0000, 32'h0,         32'h0,         1'b1, 32'h0,         0);
`else
      access("LW mis",  1, 0, 3'd0, 32'h0000_2002, 32'h0,         32'h8765_4321, 0,    1, 4'b1111, 32'h0000_2000, 32'h0,         1'b0, 32'h8765_4321, 0);
`endif

      // Reset in the middle of a bus cycle; req_valid stays held as the
      // pipeline would while stalled.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rd    = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_lsbwh = 3'd0;
      bus.req_addr  = 32'h0000_8000;
      bus.mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre-reset mem_req", 32'(bus.mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-BUS reset mem_req", 32'(bus.mem_req), 32'd0);
      chk("mid-BUS reset stall",   32'(bus.stall), 32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_rd    = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post-reset resp_valid", 32'(bus.resp_valid), 32'd0);
         chk("post-reset mem_req",    32'(bus.mem_req), 32'd0);
      end
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
